// File: rtl/bf8_pkg.sv
// bf8_pkg: shared definitions for the BrainForge8 interrupt controller.
//   Vector IDs, mask constants, controller FSM state type and the
//   priority encoder (lowest set bit = highest priority).
package bf8_pkg;

   localparam int NUM_VEC      = 16;
   localparam int VEC_RESET    = 0;
   localparam int VEC_STK_OVER = 1;
   localparam int VEC_STK_UNDR = 2;
   localparam int VEC_DMA_FAIL = 3;
   localparam int VEC_DMA_DONE = 4;
   localparam int VEC_INT0     = 5;
   localparam int VEC_SW_FIRST = 9;
   localparam int VEC_SW_LAST  = 15;

   // Vectors 1 and 2 can never be masked off.
   localparam logic [NUM_VEC-1:0] NMI_MASK   = 16'h0006;
   localparam logic [NUM_VEC-1:0] MASK_RESET = NMI_MASK;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_SERVICE = 2'd2
   } ctrl_state_e;

   // Returns the index of the lowest set bit; 0 when nothing is set.
   function automatic logic [3:0] prio_enc(input logic [NUM_VEC-1:0] v);
      logic [3:0] id;
      id = '0;
      for (int i = NUM_VEC-1; i >= 0; i--) begin
         if (v[i]) id = 4'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/bf8_sync_edge.sv
// bf8_sync_edge: STAGES-deep synchroniser followed by a rising-edge detector.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears all flops
//   d_i    : asynchronous input lines
//   rise_o : one-cycle pulse per synchronised 0->1 transition
module bf8_sync_edge #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] rise_o
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]             prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/bf8_int_ctrl.sv
// bf8_int_ctrl: BrainForge8 interrupt controller.
//   Gathers external INT lines, DMA / stack-fault pulses and software traps
//   into a pending set, presents the highest-priority enabled vector to the
//   core with an ACK/EOI handshake, and stretches RST into RESET_ON.
//   clk_i                  : system clock
//   rst_i                  : synchronous active-high reset
//   int_i[3:0]             : async external lines, rising-edge sensitive
//   trig_on_i / trig_id_i  : software trap strobe and vector (9..15 only)
//   trig_dma_done_i, trig_dma_fail_i, trig_stk_over_i, trig_stk_undr_i : pulses
//   mask_we_i / mask_d_i   : enable mask load
//   ack_i / eoi_i          : core handshake
//   next_on_o / next_id_o  : presented vector
//   reset_on_o             : global reset
//   irq_o                  : mirrors next_on_o
module bf8_int_ctrl
   import bf8_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int RESET_CYCLES = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [3:0]         int_i,
   input  logic               trig_on_i,
   input  logic [3:0]         trig_id_i,
   input  logic               trig_dma_done_i,
   input  logic               trig_dma_fail_i,
   input  logic               trig_stk_over_i,
   input  logic               trig_stk_undr_i,
   input  logic               mask_we_i,
   input  logic [NUM_VEC-1:0] mask_d_i,
   input  logic               ack_i,
   input  logic               eoi_i,
   output logic               next_on_o,
   output logic [3:0]         next_id_o,
   output logic               reset_on_o,
   output logic               irq_o
);

   logic [7:0]         rst_cnt_q;
   logic [NUM_VEC-1:0] pend_q, pend_d;
   logic [NUM_VEC-1:0] mask_q, mask_d;
   logic [NUM_VEC-1:0] set_vec, clr_vec, cand;
   logic [3:0]         int_rise;
   logic [3:0]         next_id_q, next_id_d;
   ctrl_state_e        state_q, state_d;
   logic               live, ack_eff, eoi_eff;

   // Reset stretcher: counter reloads every RST cycle, RESET_ON holds while nonzero.
   always_ff @(posedge clk_i) begin
      if (rst_i)               rst_cnt_q <= 8'(RESET_CYCLES);
      else if (rst_cnt_q != 0) rst_cnt_q <= rst_cnt_q - 8'd1;
   end

   assign reset_on_o = rst_i | (rst_cnt_q != 8'd0);
   assign live       = ~reset_on_o;

   bf8_sync_edge #(.WIDTH(4), .STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .d_i    (int_i),
      .rise_o (int_rise)
   );

   always_comb begin
      set_vec = '0;
      set_vec[VEC_STK_OVER]   = trig_stk_over_i;
      set_vec[VEC_STK_UNDR]   = trig_stk_undr_i;
      set_vec[VEC_DMA_FAIL]   = trig_dma_fail_i;
      set_vec[VEC_DMA_DONE]   = trig_dma_done_i;
      set_vec[VEC_INT0 +: 4]  = int_rise;
      if (trig_on_i && trig_id_i >= 4'(VEC_SW_FIRST)) set_vec[trig_id_i] = 1'b1;
      if (!live) set_vec = '0;
   end

   // EOI only counts in service, ACK only while presenting; these are disjoint,
   // so a combined EOI+ACK in PRESENT ends up in service.
   assign eoi_eff = live & eoi_i & (state_q == ST_SERVICE);
   assign ack_eff = live & ack_i & (state_q == ST_PRESENT);

   // Set is OR'd after the clear so a same-cycle set wins.
   assign clr_vec = ack_eff ? (16'(1) << next_id_q) : '0;
   assign pend_d  = (pend_q & ~clr_vec) | set_vec;
   assign mask_d  = (live && mask_we_i) ? (mask_d_i | NMI_MASK) : mask_q;
   assign cand    = pend_q & mask_q;

   always_comb begin
      state_d   = state_q;
      next_id_d = next_id_q;
      if (ack_eff) begin
         state_d = ST_SERVICE;
      end else if (state_q == ST_SERVICE && !eoi_eff) begin
         state_d = ST_SERVICE;
      end else if (cand != '0) begin
         state_d   = ST_PRESENT;
         next_id_d = prio_enc(cand);
      end else begin
         state_d   = ST_IDLE;
         next_id_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_q    <= '0;
         mask_q    <= MASK_RESET;
         state_q   <= ST_IDLE;
         next_id_q <= '0;
      end else begin
         pend_q    <= pend_d;
         mask_q    <= mask_d;
         state_q   <= state_d;
         next_id_q <= next_id_d;
      end
   end

   assign next_on_o = (state_q == ST_PRESENT);
   assign next_id_o = next_id_q;
   assign irq_o     = next_on_o;

endmodule

// File: tb/tb_bf8_int_ctrl.sv
module tb_bf8_int_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  int_l;
   logic        trig_on;
   logic [3:0]  trig_id;
   logic        dma_done, dma_fail, stk_over, stk_undr;
   logic        mask_we;
   logic [15:0] mask_d;
   logic        ack, eoi;
   logic        next_on, reset_on, irq;
   logic [3:0]  next_id;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bf8_int_ctrl #(.SYNC_STAGES(2), .RESET_CYCLES(4)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .int_i           (int_l),
      .trig_on_i       (trig_on),
      .trig_id_i       (trig_id),
      .trig_dma_done_i (dma_done),
      .trig_dma_fail_i (dma_fail),
      .trig_stk_over_i (stk_over),
      .trig_stk_undr_i (stk_undr),
      .mask_we_i       (mask_we),
      .mask_d_i        (mask_d),
      .ack_i           (ack),
      .eoi_i           (eoi),
      .next_on_o       (next_on),
      .next_id_o       (next_id),
      .reset_on_o      (reset_on),
      .irq_o           (irq)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance n rising edges; inputs change and outputs are sampled 1ns later.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_ack();
      ack = 1'b1; step(1); ack = 1'b0;
   endtask

   task automatic do_eoi();
      eoi = 1'b1; step(1); eoi = 1'b0;
   endtask

   task automatic wr_mask(input logic [15:0] m);
      mask_we = 1'b1; mask_d = m; step(1); mask_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; int_l = '0; trig_on = 0; trig_id = '0;
      dma_done = 0; dma_fail = 0; stk_over = 0; stk_undr = 0;
      mask_we = 0; mask_d = '0; ack = 0; eoi = 0;

      // reset and stretch with restart
      step(3);
      chk("rst_reset_on", 16'(reset_on), 16'd1);
      chk("rst_next_on",  16'(next_on),  16'd0);
      chk("rst_next_id",  16'(next_id),  16'd0);
      chk("rst_irq",      16'(irq),      16'd0);
      rst = 1'b0;
      step(2);
      chk("stretch_cnt2", 16'(reset_on), 16'd1);
      rst = 1'b1; step(1); rst = 1'b0;
      step(3);
      chk("stretch_restart", 16'(reset_on), 16'd1);
      step(1);
      chk("stretch_done", 16'(reset_on), 16'd0);

      // priority: DMA_DONE (4) beats INT2 (7)
      wr_mask(16'hFFFF);
      int_l[2] = 1'b1;
      step(2);
      dma_done = 1'b1; step(1); dma_done = 1'b0;
      step(1);
      chk("prio_on", 16'(next_on), 16'd1);
      chk("prio_id4", 16'(next_id), 16'd4);
      do_ack();
      chk("prio_ack_drop", 16'(next_on), 16'd0);
      do_eoi();
      chk("prio_id7", 16'(next_id), 16'd7);
      chk("prio_irq", 16'(irq), 16'd1);
      do_ack(); do_eoi();
      step(3);
      chk("level_once", 16'(next_on), 16'd0);

      // preemption by STK_OVER; pending 9 survives
      trig_on = 1'b1; trig_id = 4'd9; step(1); trig_on = 1'b0;
      step(1);
      chk("pre_id9", 16'(next_id), 16'd9);
      stk_over = 1'b1; step(1); stk_over = 1'b0;
      step(1);
      chk("pre_id1", 16'(next_id), 16'd1);
      do_ack();
      chk("pre_ack_drop", 16'(next_on), 16'd0);
      do_eoi();
      chk("pre_keep9_on", 16'(next_on), 16'd1);
      chk("pre_keep9_id", 16'(next_id), 16'd9);
      do_ack(); do_eoi();

      // masking: INT0 masked stays pending, NMI still gets through
      wr_mask(16'h0000);
      int_l[0] = 1'b1;
      step(4);
      chk("mask_int0_off", 16'(next_on), 16'd0);
      stk_undr = 1'b1; step(1); stk_undr = 1'b0;
      step(1);
      chk("mask_nmi_id2", 16'(next_id), 16'd2);
      chk("mask_nmi_on", 16'(next_on), 16'd1);
      wr_mask(16'h0020);
      do_ack(); do_eoi();
      chk("mask_id5", 16'(next_id), 16'd5);
      chk("mask_id5_on", 16'(next_on), 16'd1);

      // same-cycle ACK of 5 and a fresh INT0 edge: bit stays pending
      int_l[0] = 1'b0;
      step(3);
      int_l[0] = 1'b1;
      step(2);
      do_ack();
      chk("setwin_drop", 16'(next_on), 16'd0);
      do_eoi();
      chk("setwin_on", 16'(next_on), 16'd1);
      chk("setwin_id5", 16'(next_id), 16'd5);

      // EOI+ACK together while presenting: ends in service
      ack = 1'b1; eoi = 1'b1; step(1); ack = 1'b0; eoi = 1'b0;
      chk("eoiack_drop", 16'(next_on), 16'd0);
      stk_over = 1'b1; step(1); stk_over = 1'b0;
      step(2);
      chk("eoiack_insvc", 16'(next_on), 16'd0);
      do_ack();
      chk("ack_ignored", 16'(next_on), 16'd0);
      do_eoi();
      chk("nmi_after_eoi_on", 16'(next_on), 16'd1);
      chk("nmi_after_eoi_id", 16'(next_id), 16'd1);
      do_ack(); do_eoi();
      step(1);
      chk("idle", 16'(next_on), 16'd0);
      do_ack();
      step(1);
      chk("idle_ack", 16'(next_on), 16'd0);

      // software traps
      wr_mask(16'hFFFF);
      trig_on = 1'b1; trig_id = 4'd3; step(1); trig_on = 1'b0;
      step(1);
      chk("sw_id3_drop", 16'(next_on), 16'd0);
      trig_on = 1'b1; trig_id = 4'd12; step(1); trig_on = 1'b0;
      step(1);
      chk("sw_id12", 16'(next_id), 16'd12);
      chk("sw_irq", 16'(irq), 16'd1);
      do_ack();

      // RST mid-service
      int_l = '0;
      rst = 1'b1; step(1);
      chk("midrst_on", 16'(next_on), 16'd0);
      chk("midrst_id", 16'(next_id), 16'd0);
      chk("midrst_irq", 16'(irq), 16'd0);
      chk("midrst_reset_on", 16'(reset_on), 16'd1);
      rst = 1'b0;
      stk_over = 1'b1; step(1); stk_over = 1'b0;
      step(3);
      chk("post_reset_on", 16'(reset_on), 16'd0);
      chk("stretch_ignored", 16'(next_on), 16'd0);
      trig_on = 1'b1; trig_id = 4'd12; step(1); trig_on = 1'b0;
      step(1);
      chk("mask_reset_val", 16'(next_on), 16'd0);
      stk_over = 1'b1; step(1); stk_over = 1'b0;
      step(1);
      chk("post_rst_nmi", 16'(next_id), 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
